// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered
//   9N1 serial receiver (9 data bits LSB first, no parity, 1 stop bit) that
//   writes completed words into a first-word-fall-through FIFO read through a
//   valid/ready handshake. Framing errors and overruns are reported as
//   one-cycle pulses.
//
// Ports
//   clock          system clock, all state on posedge
//   reset          asynchronous active-low reset
//   rx             serial line, idles high, asynchronous to clock
//   data[8:0]      FIFO head word, 0 whenever valid is low
//   valid          FIFO not empty
//   ready          consumer accepts the head word
//   framing_error  one-cycle pulse: stop bit sampled low
//   overrun        one-cycle pulse: completed word dropped, FIFO full
//   count          number of occupied FIFO entries
//   state_dbg      receiver FSM state (encoding of state_t below)
//
// Handshake: a word transfers on every rising clock edge where valid && ready
// are both high. valid never depends on ready; data is stable while valid is
// high and not yet accepted. A word pushed in some cycle becomes visible on
// the following edge, so it can be accepted no earlier than the cycle after.

module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               rx,
  output logic [8:0]                         data,
  output logic                               valid,
  input  logic                               ready,
  output logic                               framing_error,
  output logic                               overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  output logic [2:0]                         state_dbg
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(H);
  localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Input synchronizer and arming
  // ---------------------------------------------------------------------------
  logic       rx_meta;
  logic       rx_s;
  logic [1:0] sync_fill;
  logic       armed;

  // sync_fill marks when rx_s holds a real sample of rx rather than its reset
  // value. Without it, the reset value of 1 would arm the receiver right after
  // a reset released mid-frame, and the low line would look like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Once the line has been seen high, armed stays set until the next reset.
  // WAIT_HIGH only exits on rx_s=1, so it is always armed on the way out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
    end else if (sync_fill[1] && rx_s) begin
      armed <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit timing and majority sampling
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt;
  logic          smp_a;
  logic          smp_b;
  logic          in_frame;
  logic          decide;
  logic          maj;

  assign in_frame = (state == S_START) || (state == S_DATA) || (state == S_STOP);
  assign decide   = in_frame && (cnt == CNT_DEC);
  assign maj      = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);

  // The cycle in which IDLE sees the start edge counts as cnt=0, so the
  // counter enters START already at 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == S_IDLE) begin
      cnt <= (state_next == S_START) ? CW'(1) : '0;
    end else if (state == S_WAIT_HIGH) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else begin
      if (cnt == CNT_S0) smp_a <= rx_s;
      if (cnt == CNT_S1) smp_b <= rx_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  logic [3:0] idx;
  logic [8:0] shreg;
  logic       push;
  logic       fe_set;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (armed && !rx_s) state_next = S_START;
      S_START:     if (decide) state_next = maj ? S_IDLE : S_DATA;
      S_DATA:      if (decide && (idx == 4'd8)) state_next = S_STOP;
      S_STOP:      if (decide) state_next = maj ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_s) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    push   = 1'b0;
    fe_set = 1'b0;
    if ((state == S_STOP) && decide) begin
      push   = maj;
      fe_set = !maj;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      shreg <= '0;
    end else if (decide) begin
      if (state == S_START) begin
        idx <= '0;
      end else if (state == S_DATA) begin
        shreg[idx] <= maj;
        idx        <= idx + 4'd1;
      end
    end
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] occ;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;
  logic        ov_set;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = !empty && ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when the consumer is taking the head.
  assign wr_en  = push && (!full || pop);
  assign ov_set = push && full && !pop;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= fe_set;
      overrun       <= ov_set;
    end
  end

  assign occ   = wr_ptr - rd_ptr;
  assign count = NW'(occ);
  assign valid = !empty;
  assign data  = empty ? 9'h000 : mem[rd_ptr[AW-1:0]];

endmodule
